// File: rtl/shared_resource_pkg.sv
// Types and defaults shared by the shared-resource arbiter and its round-robin core.
package shared_resource_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_LAT    = 3;

  typedef enum logic {
    OWN_1 = 1'b0,
    OWN_2 = 1'b1
  } owner_e;

  // live: response still wanted by its owner (cleared by flush)
  // pending: a response is due from the resource (never cleared by flush)
  typedef struct packed {
    logic   live;
    logic   pending;
    owner_e owner;
  } tag_t;

  // Drop the live bit of a tag whose owner is flushing this cycle.
  function automatic tag_t flush_tag(input tag_t t, input logic flush_1, input logic flush_2);
    tag_t r;
    r = t;
    if ((t.owner == OWN_1 && flush_1) || (t.owner == OWN_2 && flush_2)) begin
      r.live = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. When both request, the one that did not
// win last time is granted. Grants are only issued while en is high.
// Handshake: a requester is served in the cycle where req[i] & grant[i]; a
// requester with req[i] & ~grant[i] must hold its request.
module rr_arbiter2
  import shared_resource_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output owner_e     last_grant
);

  owner_e last_grant_d;

  // Grant selection and next round-robin pointer.
  always_comb begin
    grant        = 2'b00;
    last_grant_d = last_grant;
    if (en) begin
      if (req == 2'b11) begin
        grant = (last_grant == OWN_1) ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
    end
    if (grant[0]) begin
      last_grant_d = OWN_1;
    end else if (grant[1]) begin
      last_grant_d = OWN_2;
    end
  end

  // Round-robin pointer; reset to requester 2 so requester 1 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= OWN_2;
    end else begin
      last_grant <= last_grant_d;
    end
  end

endmodule

// File: rtl/shared_resource_arbiter.sv
// Shares one fixed-latency resource between two pipelines. Issues at most one
// request per cycle, tracks in-flight ops in a LAT-deep tag pipeline and steers
// each response back to its owner, discarding responses of flushed owners.
// Handshake: a request is accepted in any cycle where req_valid_i & ~req_flush_i
// & ~stall_i; the issue reaches the resource as res_valid (only while res_ready).
module shared_resource_arbiter
  import shared_resource_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int LAT    = DEFAULT_LAT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_1,
  input  logic              req_valid_2,
  input  logic [DATA_W-1:0] req_data_1,
  input  logic [DATA_W-1:0] req_data_2,
  input  logic              req_flush_1,
  input  logic              req_flush_2,
  output logic              stall_1,
  output logic              stall_2,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ready,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              out_valid_1,
  output logic              out_valid_2,
  output logic [DATA_W-1:0] out_data_1,
  output logic [DATA_W-1:0] out_data_2,
  output logic [CNT_W-1:0]  grant_cnt_1,
  output logic [CNT_W-1:0]  grant_cnt_2,
  output logic              err_unexpected
);

  logic [1:0] elig;
  logic [1:0] grant;
  owner_e     last_grant;
  owner_e     winner;
  tag_t       tag_in;
  tag_t       tag_q [LAT];
  tag_t       aligned;
  tag_t       aligned_f;
  logic       hit;

  assign elig = {req_valid_2 & ~req_flush_2, req_valid_1 & ~req_flush_1};

  rr_arbiter2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .en         (res_ready),
    .req        (elig),
    .grant      (grant),
    .last_grant (last_grant)
  );

  // Issue path: winner's payload to the resource, stalls to the losers.
  always_comb begin
    winner    = grant[1] ? OWN_2 : OWN_1;
    stall_1   = elig[0] & ~grant[0];
    stall_2   = elig[1] & ~grant[1];
    res_valid = |grant;
    res_data  = '0;
    if (grant[0]) begin
      res_data = req_data_1;
    end else if (grant[1]) begin
      res_data = req_data_2;
    end
    tag_in.live    = |grant;
    tag_in.pending = |grant;
    tag_in.owner   = winner;
  end

  // The last stage lines up with rsp_valid; a flush this cycle still kills it.
  always_comb begin
    aligned   = tag_q[LAT-1];
    aligned_f = flush_tag(aligned, req_flush_1, req_flush_2);
    hit       = rsp_valid & aligned.pending & aligned_f.live;
  end

  // Tag shift register; flush clears live on entries of the flushing owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0] <= flush_tag(tag_in, req_flush_1, req_flush_2);
      for (int k = 1; k < LAT; k++) begin
        tag_q[k] <= flush_tag(tag_q[k-1], req_flush_1, req_flush_2);
      end
    end
  end

  // Registered response steering, sticky error flag and saturating grant counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_1    <= 1'b0;
      out_valid_2    <= 1'b0;
      out_data_1     <= '0;
      out_data_2     <= '0;
      err_unexpected <= 1'b0;
      grant_cnt_1    <= '0;
      grant_cnt_2    <= '0;
    end else begin
      out_valid_1 <= hit & (aligned.owner == OWN_1);
      out_valid_2 <= hit & (aligned.owner == OWN_2);
      if (hit && aligned.owner == OWN_1) begin
        out_data_1 <= rsp_data;
      end
      if (hit && aligned.owner == OWN_2) begin
        out_data_2 <= rsp_data;
      end
      if (rsp_valid != aligned.pending) begin
        err_unexpected <= 1'b1;
      end
      if (grant[0] && grant_cnt_1 != '1) begin
        grant_cnt_1 <= grant_cnt_1 + 1'b1;
      end
      if (grant[1] && grant_cnt_2 != '1) begin
        grant_cnt_2 <= grant_cnt_2 + 1'b1;
      end
    end
  end

  // A tie must always go to the requester that did not win last time.
  always_ff @(posedge clk) begin
    if (!reset && res_ready && elig == 2'b11) begin
      assert (winner != last_grant);
    end
  end

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Bench for shared_resource_arbiter: a behavioural resource answers every issue
// after LAT cycles with payload ^ 0xFF; expected responses are queued when the
// request is driven and matched (cycle, port, data) when out_valid appears.
module tb_shared_resource_arbiter;

  localparam int DATA_W = 32;
  localparam int LAT    = 3;
  localparam int CNT_W  = 4;
  localparam int EW     = 32 + 1 + DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid_1, req_valid_2;
  logic [DATA_W-1:0] req_data_1, req_data_2;
  logic              req_flush_1, req_flush_2;
  logic              stall_1, stall_2;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              out_valid_1, out_valid_2;
  logic [DATA_W-1:0] out_data_1, out_data_2;
  logic [CNT_W-1:0]  grant_cnt_1, grant_cnt_2;
  logic              err_unexpected;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [EW-1:0] mon_a;

  // reference model state
  int               m_last;
  logic [CNT_W-1:0] mc1, mc2;

  // behavioural resource
  logic              auto_rsp = 1'b1;
  logic              man_rsp  = 1'b0;
  logic [LAT-1:0]    rv_pipe;
  logic [DATA_W-1:0] rd_pipe [LAT];

  shared_resource_arbiter #(.DATA_W(DATA_W), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid_1    (req_valid_1),
    .req_valid_2    (req_valid_2),
    .req_data_1     (req_data_1),
    .req_data_2     (req_data_2),
    .req_flush_1    (req_flush_1),
    .req_flush_2    (req_flush_2),
    .stall_1        (stall_1),
    .stall_2        (stall_2),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .res_ready      (res_ready),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .out_valid_1    (out_valid_1),
    .out_valid_2    (out_valid_2),
    .out_data_1     (out_data_1),
    .out_data_2     (out_data_2),
    .grant_cnt_1    (grant_cnt_1),
    .grant_cnt_2    (grant_cnt_2),
    .err_unexpected (err_unexpected)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // resource: answers every accepted issue LAT cycles later
  always @(posedge clk) begin
    if (reset) begin
      rv_pipe <= '0;
      for (int k = 0; k < LAT; k++) rd_pipe[k] <= '0;
    end else begin
      rv_pipe    <= {rv_pipe[LAT-2:0], res_valid & res_ready & auto_rsp};
      rd_pipe[0] <= res_data;
      for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
  end
  assign rsp_valid = rv_pipe[LAT-1] | man_rsp;
  assign rsp_data  = rv_pipe[LAT-1] ? (rd_pipe[LAT-1] ^ 32'hFF) : '0;

  // output monitor: pops the scoreboard on every out_valid
  always @(negedge clk) begin
    if (!reset) begin
      while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
        mon_e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_rsp cyc=%0d got none required port=%0d data=%h at cyc %0d",
                 cyc, mon_e[DATA_W], mon_e[DATA_W-1:0], mon_e[EW-1 -: 32]);
      end
      if (out_valid_1 || out_valid_2) begin
        checks++;
        mon_a = {32'(cyc), out_valid_2, out_valid_2 ? out_data_2 : out_data_1};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp cyc=%0d got ov1=%b ov2=%b required none",
                   cyc, out_valid_1, out_valid_2);
        end else begin
          mon_e = exp_q.pop_front();
          if ((out_valid_1 && out_valid_2) || mon_a !== mon_e) begin
            errors++;
            $display("FAIL rsp cyc=%0d got ov1=%b ov2=%b data=%h required port=%0d data=%h cyc=%0d",
                     cyc, out_valid_1, out_valid_2, mon_a[DATA_W-1:0],
                     mon_e[DATA_W], mon_e[DATA_W-1:0], mon_e[EW-1 -: 32]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    req_valid_1 = 1'b0; req_valid_2 = 1'b0;
    req_data_1  = '0;   req_data_2  = '0;
    req_flush_1 = 1'b0; req_flush_2 = 1'b0;
    res_ready   = 1'b1;
    man_rsp     = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    m_last = 2; mc1 = '0; mc2 = '0;
    @(negedge clk);
  endtask

  // drop expected responses a flush in this cycle kills (out_valid at cyc+1 or later)
  task automatic flush_exp(input logic f1, input logic f2);
    logic [EW-1:0] keep[$];
    for (int k = 0; k < exp_q.size(); k++) begin
      if (!(int'(exp_q[k][EW-1 -: 32]) >= cyc + 1 &&
            ((exp_q[k][DATA_W] == 1'b0 && f1) || (exp_q[k][DATA_W] == 1'b1 && f2))))
        keep.push_back(exp_q[k]);
    end
    exp_q = keep;
  endtask

  // drive one cycle, update the model, return at the following negedge
  task automatic drive_cycle(input logic v1, input logic [DATA_W-1:0] d1, input logic f1,
                             input logic v2, input logic [DATA_W-1:0] d2, input logic f2,
                             input logic rdy, output int win);
    logic e1, e2;
    @(posedge clk); #1;
    req_valid_1 = v1; req_data_1 = d1; req_flush_1 = f1;
    req_valid_2 = v2; req_data_2 = d2; req_flush_2 = f2;
    res_ready   = rdy;
    e1 = v1 & ~f1; e2 = v2 & ~f2;
    win = 0;
    if (rdy) begin
      if (e1 && e2) win = (m_last == 1) ? 2 : 1;
      else if (e1)  win = 1;
      else if (e2)  win = 2;
    end
    flush_exp(f1, f2);
    if (win == 1) begin
      exp_q.push_back({32'(cyc + LAT + 1), 1'b0, d1 ^ 32'hFF});
      if (mc1 != '1) mc1 = mc1 + 1'b1;
    end else if (win == 2) begin
      exp_q.push_back({32'(cyc + LAT + 1), 1'b1, d2 ^ 32'hFF});
      if (mc2 != '1) mc2 = mc2 + 1'b1;
    end
    if (win != 0) m_last = win;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    int w;
    repeat (n) drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, w);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks += 6;
    if (stall_1 !== 1'b0 || stall_2 !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b%b required 00", stall_1, stall_2);
    end
    if (res_valid !== 1'b0 || res_data !== '0) begin
      errors++; $display("FAIL reset_res got v=%b d=%h required 0 0", res_valid, res_data);
    end
    if (out_valid_1 !== 1'b0 || out_valid_2 !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b%b required 00", out_valid_1, out_valid_2);
    end
    if (out_data_1 !== '0 || out_data_2 !== '0) begin
      errors++; $display("FAIL reset_out_data got %h %h required 0 0", out_data_1, out_data_2);
    end
    if (grant_cnt_1 !== '0 || grant_cnt_2 !== '0) begin
      errors++; $display("FAIL reset_cnt got %0d %0d required 0 0", grant_cnt_1, grant_cnt_2);
    end
    if (err_unexpected !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b required 0", err_unexpected);
    end
  endtask

  task automatic test_single();
    int w;
    do_reset();
    drive_cycle(1'b1, 32'hA5, 1'b0, 1'b0, '0, 1'b0, 1'b1, w);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 32'hA5 || stall_1 !== 1'b0) begin
      errors++; $display("FAIL single_issue got v=%b d=%h s1=%b required 1 a5 0", res_valid, res_data, stall_1);
    end
    repeat (LAT + 2) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, w);
      checks++;
      if (stall_1 !== 1'b0) begin
        errors++; $display("FAIL single_stall got %b required 0", stall_1);
      end
    end
    checks += 2;
    if (out_data_1 !== 32'h5A) begin
      errors++; $display("FAIL single_out_data_hold got %h required 5a", out_data_1);
    end
    if (grant_cnt_1 !== 4'd1) begin
      errors++; $display("FAIL single_cnt got %0d required 1", grant_cnt_1);
    end
  endtask

  task automatic test_contention();
    int w;
    logic exp_s1, exp_s2;
    logic [DATA_W-1:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 32'h100 + i, 1'b0, 1'b1, 32'h200 + i, 1'b0, 1'b1, w);
      exp_s1 = (i % 2 == 1);
      exp_s2 = (i % 2 == 0);
      exp_d  = (i % 2 == 0) ? 32'h100 + i : 32'h200 + i;
      checks++;
      if (stall_1 !== exp_s1 || stall_2 !== exp_s2 || res_valid !== 1'b1 || res_data !== exp_d) begin
        errors++; $display("FAIL contention_c%0d got s1=%b s2=%b d=%h required s1=%b s2=%b d=%h",
                           i, stall_1, stall_2, res_data, exp_s1, exp_s2, exp_d);
      end
    end
    idle(LAT + 2);
    checks += 2;
    if (grant_cnt_1 !== 4'd2 || grant_cnt_2 !== 4'd2) begin
      errors++; $display("FAIL contention_cnt got %0d %0d required 2 2", grant_cnt_1, grant_cnt_2);
    end
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL contention_drain got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int w;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 32'h31, 1'b0, 1'b1, 32'h32, 1'b0, 1'b0, w);
      checks++;
      if (stall_1 !== 1'b1 || stall_2 !== 1'b1 || res_valid !== 1'b0 || res_data !== '0) begin
        errors++; $display("FAIL bp_hold got s1=%b s2=%b v=%b d=%h required 1 1 0 0",
                           stall_1, stall_2, res_valid, res_data);
      end
    end
    drive_cycle(1'b1, 32'h31, 1'b0, 1'b1, 32'h32, 1'b0, 1'b1, w);
    checks += 2;
    if (grant_cnt_1 !== '0 || grant_cnt_2 !== '0) begin
      errors++; $display("FAIL bp_cnt got %0d %0d required 0 0", grant_cnt_1, grant_cnt_2);
    end
    if (stall_1 !== 1'b0 || stall_2 !== 1'b1 || res_data !== 32'h31) begin
      errors++; $display("FAIL bp_first got s1=%b s2=%b d=%h required 0 1 31", stall_1, stall_2, res_data);
    end
    idle(LAT + 2);
  endtask

  task automatic test_flush();
    int w;
    do_reset();
    drive_cycle(1'b1, 32'h11, 1'b0, 1'b0, '0, 1'b0, 1'b1, w);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, 32'h22, 1'b0, 1'b1, w);
    drive_cycle(1'b1, 32'h33, 1'b1, 1'b0, '0, 1'b0, 1'b1, w);
    checks++;
    if (stall_1 !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drop got s1=%b v=%b required 0 0", stall_1, res_valid);
    end
    idle(LAT + 2);
    checks += 2;
    if (err_unexpected !== 1'b0) begin
      errors++; $display("FAIL flush_err got %b required 0", err_unexpected);
    end
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL flush_drain got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_error();
    int w;
    do_reset();
    idle(2);
    man_rsp = 1'b1;
    idle(1);
    man_rsp = 1'b0;
    checks++;
    if (err_unexpected !== 1'b1) begin
      errors++; $display("FAIL err_stray got %b required 1", err_unexpected);
    end
    idle(5);
    checks++;
    if (err_unexpected !== 1'b1) begin
      errors++; $display("FAIL err_sticky got %b required 1", err_unexpected);
    end
    do_reset();
    checks++;
    if (err_unexpected !== 1'b0) begin
      errors++; $display("FAIL err_cleared got %b required 0", err_unexpected);
    end
    // resource silently drops an issue
    auto_rsp = 1'b0;
    drive_cycle(1'b1, 32'h44, 1'b0, 1'b0, '0, 1'b0, 1'b1, w);
    exp_q.delete();
    idle(LAT);
    checks++;
    if (err_unexpected !== 1'b0) begin
      errors++; $display("FAIL err_missing_early got %b required 0", err_unexpected);
    end
    idle(1);
    checks++;
    if (err_unexpected !== 1'b1) begin
      errors++; $display("FAIL err_missing got %b required 1", err_unexpected);
    end
    auto_rsp = 1'b1;
  endtask

  task automatic test_saturation();
    int w;
    do_reset();
    repeat (20) drive_cycle(1'b1, DATA_W'($urandom_range(0, 255)), 1'b0, 1'b0, '0, 1'b0, 1'b1, w);
    idle(LAT + 2);
    checks++;
    if (grant_cnt_1 !== 4'd15 || grant_cnt_2 !== 4'd0) begin
      errors++; $display("FAIL sat_cnt got %0d %0d required 15 0", grant_cnt_1, grant_cnt_2);
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic v1, v2, f1, f2, rdy;
    logic [DATA_W-1:0] d1, d2, exp_d;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      v1  = 1'($urandom_range(0, 1));
      v2  = 1'($urandom_range(0, 1));
      f1  = ($urandom_range(0, 9) == 0);
      f2  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      d1  = $urandom;
      d2  = $urandom;
      drive_cycle(v1, d1, f1, v2, d2, f2, rdy, w);
      exp_d = (w == 1) ? d1 : (w == 2) ? d2 : '0;
      checks++;
      if (stall_1 !== (v1 & ~f1 & (w != 1)) || stall_2 !== (v2 & ~f2 & (w != 2)) ||
          res_valid !== (w != 0) || res_data !== exp_d) begin
        errors++; $display("FAIL b2b_issue c%0d got s1=%b s2=%b v=%b d=%h required win=%0d d=%h",
                           i, stall_1, stall_2, res_valid, res_data, w, exp_d);
      end
    end
    idle(LAT + 2);
    checks += 2;
    if (grant_cnt_1 !== mc1 || grant_cnt_2 !== mc2) begin
      errors++; $display("FAIL b2b_cnt got %0d %0d required %0d %0d", grant_cnt_1, grant_cnt_2, mc1, mc2);
    end
    if (err_unexpected !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_end got err=%b pending=%0d required 0 0", err_unexpected, exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flush();
    test_error();
    test_saturation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
